// File: rtl/cpu_bus_target.sv
// cpu_bus_target: 68030-style bus responder for cycles mastered by the SDMAC CPU state
// machine. AS_/DS_ are synchronised, WAIT_CNT wait states are inserted, and the cycle is
// then terminated with DSACK1_/DSACK0_ for a 32-bit port, or with DSACK1_ only for a
// 16-bit port. The backing store is a word-addressed RAM with byte-lane writes.
//
// Ports:
//   CLK, RST            clock; synchronous active-high reset
//   AS_, DS_            address/data strobes, active low, asynchronous to CLK
//   R_W, SIZ, ADDR      direction (1 = read), transfer size, byte address
//   DATA_IN             write data; port byte lane n = DATA_IN[31-8n -: 8]
//   WAIT_CNT            wait states, sampled at cycle start
//   DATA_OUT, DATA_OE   read data and its bus-drive enable
//   DSACK0_, DSACK1_    data-transfer acknowledge, active low
//   CYC_CNT             count of acknowledged cycles, wrapping
module cpu_bus_target #(
  parameter int unsigned ADDR_W = 6,
  parameter bit          PORT16 = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              AS_,
  input  logic              DS_,
  input  logic              R_W,
  input  logic [1:0]        SIZ,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [31:0]       DATA_IN,
  input  logic [3:0]        WAIT_CNT,
  output logic [31:0]       DATA_OUT,
  output logic              DATA_OE,
  output logic              DSACK0_,
  output logic              DSACK1_,
  output logic [15:0]       CYC_CNT
);

  localparam int unsigned Depth = 2 ** (ADDR_W - 2);

  typedef enum logic [1:0] {StIdle, StWait, StAck, StHold} state_e;

  state_e state_q, state_d;
  logic as_q1, as_s, ds_q1, ds_s;
  logic armed_q;
  logic [3:0] wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0] siz_q;
  logic rw_q;
  logic [31:0] data_q;
  logic [15:0] cyc_q;
  logic [31:0] mem [Depth];

  logic start, ack_go, rel, wr_go;
  logic [ADDR_W-1:0] cur_addr;
  logic [1:0] cur_siz;
  logic cur_rw;
  logic [31:0] cur_data;
  logic [ADDR_W-3:0] cur_idx;
  logic [1:0] lane_start;
  logic [2:0] lane_cnt, lane_end;
  logic [3:0] en, be;
  logic [31:0] wdata, rd_word, rd_data;

  assign CYC_CNT = cyc_q;

  // A cycle begun this edge acts on the live bus inputs; later states use the latched copy.
  always_comb begin
    cur_addr = addr_q;
    cur_siz  = siz_q;
    cur_rw   = rw_q;
    cur_data = data_q;
    if (state_q == StIdle) begin
      cur_addr = ADDR;
      cur_siz  = SIZ;
      cur_rw   = R_W;
      cur_data = DATA_IN;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    start   = 1'b0;
    ack_go  = 1'b0;
    rel     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // armed_q stops a strobe held low from starting a second cycle.
        if (armed_q && !as_s && !ds_s) begin
          start  = 1'b1;
          wcnt_d = WAIT_CNT;
          if (WAIT_CNT == 4'd0) begin
            ack_go  = 1'b1;
            state_d = StAck;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (as_s) begin
          state_d = StIdle;
        end else if (wcnt_q == 4'd1) begin
          ack_go  = 1'b1;
          state_d = StAck;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      StAck: state_d = StHold;
      StHold: begin
        if (as_s) begin
          rel     = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Byte lanes: start lane, SIZ bytes (00 = 4), clipped at the last port lane.
  always_comb begin
    cur_idx    = cur_addr[ADDR_W-1:2];
    lane_start = PORT16 ? {1'b0, cur_addr[0]} : cur_addr[1:0];
    lane_cnt   = (cur_siz == 2'b00) ? 3'd4 : {1'b0, cur_siz};
    lane_end   = {1'b0, lane_start} + lane_cnt;
    en         = '0;
    for (int n = 0; n < 4; n++) begin
      en[n] = (3'(n) >= {1'b0, lane_start}) && (3'(n) < lane_end) && (!PORT16 || n < 2);
    end
    rd_word = mem[cur_idx];
    if (PORT16) begin
      // Port lanes 0/1 map onto RAM bytes 0/1 (upper half) or 2/3 (lower half).
      be      = cur_addr[1] ? {en[1], en[0], 2'b00} : {2'b00, en[1], en[0]};
      wdata   = {cur_data[31:16], cur_data[31:16]};
      rd_data = cur_addr[1] ? {rd_word[15:0], 16'h0000} : {rd_word[31:16], 16'h0000};
    end else begin
      be      = en;
      wdata   = cur_data;
      rd_data = rd_word;
    end
  end

  assign wr_go = ack_go && !cur_rw && !RST;

  always_ff @(posedge CLK) begin
    if (wr_go) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[cur_idx][31-8*b -: 8] <= wdata[31-8*b -: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      as_q1    <= 1'b1;
      as_s     <= 1'b1;
      ds_q1    <= 1'b1;
      ds_s     <= 1'b1;
      armed_q  <= 1'b0;
      state_q  <= StIdle;
      wcnt_q   <= 4'd0;
      addr_q   <= '0;
      siz_q    <= 2'b00;
      rw_q     <= 1'b0;
      data_q   <= 32'h0;
      cyc_q    <= 16'h0000;
      DATA_OUT <= 32'h0;
      DATA_OE  <= 1'b0;
      DSACK0_  <= 1'b1;
      DSACK1_  <= 1'b1;
    end else begin
      as_q1   <= AS_;
      as_s    <= as_q1;
      ds_q1   <= DS_;
      ds_s    <= ds_q1;
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (start) armed_q <= 1'b0;
      else if (as_s) armed_q <= 1'b1;
      if (start) begin
        addr_q <= ADDR;
        siz_q  <= SIZ;
        rw_q   <= R_W;
        data_q <= DATA_IN;
      end
      if (ack_go) begin
        DSACK1_ <= 1'b0;
        DSACK0_ <= PORT16;
        cyc_q   <= cyc_q + 16'd1;
        if (cur_rw) begin
          DATA_OUT <= rd_data;
          DATA_OE  <= 1'b1;
        end
      end else if (rel) begin
        DSACK1_ <= 1'b1;
        DSACK0_ <= 1'b1;
        DATA_OE <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_target.sv
module tb_cpu_bus_target;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        as_n = 1'b1, ds_n = 1'b1, r_w = 1'b0;
  logic [1:0]  siz = 2'b00;
  logic [5:0]  addr = '0;
  logic [31:0] data_in = '0;
  logic [3:0]  wait_cnt = '0;

  logic [31:0] dout32, dout16;
  logic        oe32, oe16, d0_32, d1_32, d0_16, d1_16;
  logic [15:0] cnt32, cnt16;

  int errors = 0;
  int checks = 0;

  // Captured at the acknowledge edge.
  logic [31:0] c_r32, c_r16;
  logic        c_oe32, c_d0_32, c_d0_16, c_d1_16;
  logic [15:0] c_cnt32;

  always #5 clk = ~clk;

  cpu_bus_target #(.ADDR_W(6), .PORT16(1'b0)) dut32 (
    .CLK(clk), .RST(rst), .AS_(as_n), .DS_(ds_n), .R_W(r_w), .SIZ(siz), .ADDR(addr),
    .DATA_IN(data_in), .WAIT_CNT(wait_cnt), .DATA_OUT(dout32), .DATA_OE(oe32),
    .DSACK0_(d0_32), .DSACK1_(d1_32), .CYC_CNT(cnt32)
  );

  cpu_bus_target #(.ADDR_W(6), .PORT16(1'b1)) dut16 (
    .CLK(clk), .RST(rst), .AS_(as_n), .DS_(ds_n), .R_W(r_w), .SIZ(siz), .ADDR(addr),
    .DATA_IN(data_in), .WAIT_CNT(wait_cnt), .DATA_OUT(dout16), .DATA_OE(oe16),
    .DSACK0_(d0_16), .DSACK1_(d1_16), .CYC_CNT(cnt16)
  );

  typedef struct {
    logic        rw;
    logic [1:0]  siz;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  w;
    logic [31:0] exp_rd;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Strobes go low before edge k; returns edges after k until DSACK1_ low (-1 on timeout).
  task automatic begin_cycle(input logic rw_i, input logic [1:0] siz_i, input logic [5:0] a,
                             input logic [31:0] d, input logic [3:0] w, output int lat);
    @(negedge clk);
    r_w = rw_i; siz = siz_i; addr = a; data_in = d; wait_cnt = w;
    as_n = 1'b0; ds_n = 1'b0;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (!d1_32) begin
        lat = i;
        break;
      end
    end
    c_r32 = dout32; c_oe32 = oe32; c_d0_32 = d0_32; c_cnt32 = cnt32;
    c_r16 = dout16; c_d0_16 = d0_16; c_d1_16 = d1_16;
  endtask

  // Holds strobes for extra edges, then negates them before edge m; expects release at m+2.
  task automatic finish_cycle(input int hold);
    int rel;
    int early;
    early = 0;
    @(negedge clk);
    for (int j = 0; j < hold; j++) begin
      @(posedge clk); #1;
      if (d1_32) early++;
    end
    if (hold > 0) check("dsack_held", early, 0);
    @(negedge clk);
    as_n = 1'b1; ds_n = 1'b1;
    rel = -1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (d1_32) begin
        rel = i;
        break;
      end
    end
    check("release_latency", rel, 2);
    check("release_oe", {31'b0, oe32}, 0);
  endtask

  task automatic bus_cycle(input logic rw_i, input logic [1:0] siz_i, input logic [5:0] a,
                           input logic [31:0] d, input logic [3:0] w, input int hold);
    int lat;
    begin_cycle(rw_i, siz_i, a, d, w, lat);
    check("ack_latency", lat, 2 + int'(w));
    finish_cycle(hold);
  endtask

  initial begin
    int lows;
    logic [15:0] cnt_before;

    vecs[0]  = '{1'b0, 2'b00, 6'h04, 32'hDEADBEEF, 4'd0, 32'h0,        16'd1};
    vecs[1]  = '{1'b1, 2'b00, 6'h04, 32'h0,        4'd0, 32'hDEADBEEF, 16'd2};
    vecs[2]  = '{1'b0, 2'b01, 6'h07, 32'h5A5A5A5A, 4'd0, 32'h0,        16'd3};
    vecs[3]  = '{1'b1, 2'b01, 6'h04, 32'h0,        4'd1, 32'hDEADBE5A, 16'd4};
    vecs[4]  = '{1'b0, 2'b00, 6'h08, 32'h01020304, 4'd2, 32'h0,        16'd5};
    vecs[5]  = '{1'b0, 2'b10, 6'h0A, 32'h0000BABE, 4'd0, 32'h0,        16'd6};
    vecs[6]  = '{1'b1, 2'b10, 6'h08, 32'h0,        4'd3, 32'h0102BABE, 16'd7};
    vecs[7]  = '{1'b0, 2'b00, 6'h0C, 32'h11223344, 4'd0, 32'h0,        16'd8};
    vecs[8]  = '{1'b0, 2'b11, 6'h0D, 32'h00A1B2C3, 4'd1, 32'h0,        16'd9};
    vecs[9]  = '{1'b1, 2'b00, 6'h0C, 32'h0,        4'd0, 32'h11A1B2C3, 16'd10};
    vecs[10] = '{1'b0, 2'b00, 6'h10, 32'h55667788, 4'd0, 32'h0,        16'd11};
    vecs[11] = '{1'b0, 2'b00, 6'h13, 32'hFFFFFF99, 4'd0, 32'h0,        16'd12};
    vecs[12] = '{1'b1, 2'b00, 6'h10, 32'h0,        4'd2, 32'h55667799, 16'd13};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_dsack1", {31'b0, d1_32}, 1);
    check("rst_dsack0", {31'b0, d0_32}, 1);
    check("rst_oe", {31'b0, oe32}, 0);
    check("rst_dout", dout32, 0);
    check("rst_cnt", {16'b0, cnt32}, 0);
    check("rst_dsack1_p16", {31'b0, d1_16}, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // 32-bit port vectors.
    for (int i = 0; i < 13; i++) begin
      bus_cycle(vecs[i].rw, vecs[i].siz, vecs[i].addr, vecs[i].data, vecs[i].w, 0);
      check("vec_dsack0", {31'b0, c_d0_32}, 0);
      check("vec_oe", {31'b0, c_oe32}, {31'b0, vecs[i].rw});
      if (vecs[i].rw) check("vec_rdata", c_r32, vecs[i].exp_rd);
      check("vec_cnt", {16'b0, c_cnt32}, {16'b0, vecs[i].exp_cnt});
    end

    // Five wait states, strobes held three extra edges.
    bus_cycle(1'b1, 2'b00, 6'h04, 32'h0, 4'd5, 3);
    check("wait5_rdata", c_r32, 32'hDEADBE5A);
    check("wait5_cnt", {16'b0, c_cnt32}, 14);

    // Abort during wait states.
    cnt_before = cnt32;
    lows = 0;
    @(negedge clk);
    r_w = 1'b0; siz = 2'b00; addr = 6'h04; data_in = 32'h0BADF00D; wait_cnt = 4'd8;
    as_n = 1'b0; ds_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (!d1_32 || !d0_32) lows++;
    end
    @(negedge clk);
    as_n = 1'b1; ds_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (!d1_32 || !d0_32) lows++;
    end
    check("abort_no_dsack", lows, 0);
    check("abort_cnt", {16'b0, cnt32}, {16'b0, cnt_before});
    bus_cycle(1'b1, 2'b00, 6'h04, 32'h0, 4'd0, 0);
    check("abort_ram_kept", c_r32, 32'hDEADBE5A);
    check("abort_cnt_next", {16'b0, c_cnt32}, 15);

    // 16-bit port.
    bus_cycle(1'b0, 2'b00, 6'h00, 32'h12345678, 4'd0, 0);
    check("p16_dsack1", {31'b0, c_d1_16}, 0);
    check("p16_dsack0", {31'b0, c_d0_16}, 1);
    bus_cycle(1'b0, 2'b10, 6'h02, 32'hABCD0000, 4'd0, 0);
    bus_cycle(1'b1, 2'b00, 6'h00, 32'h0, 4'd0, 0);
    check("p16_read_upper", c_r16, 32'h12340000);
    bus_cycle(1'b0, 2'b01, 6'h03, 32'h00EE0000, 4'd1, 0);
    bus_cycle(1'b1, 2'b10, 6'h02, 32'h0, 4'd0, 0);
    check("p16_read_lower", c_r16, 32'hABEE0000);
    bus_cycle(1'b0, 2'b00, 6'h01, 32'h11773344, 4'd0, 0);
    bus_cycle(1'b1, 2'b00, 6'h00, 32'h0, 4'd0, 0);
    check("p16_clip", c_r16, 32'h12770000);

    // Reset while in HOLD.
    begin
      int lat;
      begin_cycle(1'b1, 2'b00, 6'h04, 32'h0, 4'd0, lat);
      check("hold_ack_latency", lat, 2);
      @(negedge clk);
      rst = 1'b1; as_n = 1'b1; ds_n = 1'b1;
      @(posedge clk); #1;
      check("hold_rst_dsack1", {31'b0, d1_32}, 1);
      check("hold_rst_dsack0", {31'b0, d0_32}, 1);
      check("hold_rst_oe", {31'b0, oe32}, 0);
      check("hold_rst_cnt", {16'b0, cnt32}, 0);
      check("hold_rst_dout", dout32, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
    end

    // Counter wrap.
    @(negedge clk);
    force dut32.cyc_q = 16'hFFFE;
    #1;
    release dut32.cyc_q;
    bus_cycle(1'b1, 2'b00, 6'h04, 32'h0, 4'd0, 0);
    check("cnt_ffff", {16'b0, c_cnt32}, 32'h0000FFFF);
    bus_cycle(1'b1, 2'b00, 6'h04, 32'h0, 4'd0, 0);
    check("cnt_wrap", {16'b0, c_cnt32}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
